// File: rtl/bcp_pkg.sv
// bcp_pkg: shared op/state encodings, status codes and command-word field offsets for the BCP accelerator
package bcp_pkg;
   typedef enum logic [1:0] {
      NO_OP            = 2'b00,
      UPDATE_CLAUSE_OP = 2'b01,
      DECISION_OP      = 2'b10,
      BACKTRACK_OP     = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_ACK,
      S_CLEAR,
      S_SETTLE,
      S_RESPOND
   } state_e;

   localparam logic [31:0] ST_DONE     = 32'd1;
   localparam logic [31:0] ST_CONFLICT = 32'd4;
   localparam logic [31:0] ST_SAT      = 32'd5;
   localparam logic [31:0] ST_IMPL     = 32'd6;

   localparam int REG0_OP_LSB  = 0;
   localparam int REG0_CID_LSB = 2;
   localparam int REGN_POL_LSB = 0;
   localparam int REGN_VID_LSB = 1;
endpackage

// File: rtl/bcp_stability_counter.sv
// bcp_stability_counter: flags a sample that has matched its predecessor for STABLE_CYCLES consecutive cycles
module bcp_stability_counter #(
   parameter int               WIDTH         = 1,
   parameter int               STABLE_CYCLES = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] sample_i,
   output logic             stable_o
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
   logic [WIDTH-1:0] prev;
   logic [CW-1:0]    cnt;
   logic             same;
   assign same     = sample_i == prev;
   assign stable_o = en_i && same && cnt == LAST;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev <= RESET_VALUE;
         cnt  <= '0;
      end else begin
         prev <= sample_i;
         cnt  <= (!en_i || !same) ? '0 : (cnt == LAST) ? cnt : cnt + 1'b1;
      end
   end
endmodule

// File: rtl/bcp_cmd_driver.sv
// bcp_cmd_driver: encodes stream commands into accelerator command words and returns one settled status response per command
module bcp_cmd_driver
   import bcp_pkg::*;
#(
   parameter int FORMULA_MAX_VARIABLE  = 20,
   parameter int VARIABLE_ENCODING_LEN = $clog2(FORMULA_MAX_VARIABLE + 1),
   parameter int MAX_CLAUSE            = 91,
   parameter int CLAUSE_ID_LEN         = $clog2(MAX_CLAUSE),
   parameter int STABLE_CYCLES         = 4,
   parameter int TIMEOUT_CYCLES        = 1024
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               cmd_valid_i,
   output logic                               cmd_ready_o,
   input  logic [1:0]                         cmd_op_i,
   input  logic [CLAUSE_ID_LEN-1:0]           cmd_clause_id_i,
   input  logic [3*VARIABLE_ENCODING_LEN-1:0] cmd_var_ids_i,
   input  logic [2:0]                         cmd_pols_i,
   output logic [31:0]                        axi_reg0_o,
   output logic [31:0]                        axi_reg1_o,
   output logic [31:0]                        axi_reg2_o,
   output logic [31:0]                        axi_reg3_o,
   input  logic [31:0]                        axi_reg4_i,
   input  logic [VARIABLE_ENCODING_LEN:0]     axi_reg5_i,
   input  logic                               cpu_op_read_i,
   output logic                               rsp_valid_o,
   input  logic                               rsp_ready_i,
   output logic [31:0]                        rsp_status_o,
   output logic [VARIABLE_ENCODING_LEN:0]     rsp_impl_o,
   output logic                               rsp_timeout_o,
   output logic                               busy_o
);
   localparam int VEL = VARIABLE_ENCODING_LEN;
   localparam int TW  = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_e        state, state_n;
   logic [TW-1:0] to_cnt;
   logic          accept, timing, timeout, stable;

   assign accept      = state == S_IDLE && cmd_valid_i && cmd_op_i != NO_OP;
   assign timing      = state inside {S_WAIT_ACK, S_CLEAR, S_SETTLE};
   assign timeout     = timing && to_cnt == TO_LAST;
   assign cmd_ready_o = state == S_IDLE;
   assign busy_o      = !cmd_ready_o;
   assign rsp_valid_o = state == S_RESPOND;

   bcp_stability_counter #(
      .WIDTH         (32 + VEL + 1),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_stab (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (state == S_SETTLE),
      .sample_i ({axi_reg5_i, axi_reg4_i}),
      .stable_o (stable)
   );

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:     state_n = accept ? S_ISSUE : S_IDLE;
         S_ISSUE:    state_n = axi_reg0_o[REG0_OP_LSB +: 2] == UPDATE_CLAUSE_OP ? S_WAIT_ACK : S_CLEAR;
         S_WAIT_ACK: state_n = timeout ? S_RESPOND : cpu_op_read_i ? S_CLEAR : S_WAIT_ACK;
         S_CLEAR:    state_n = timeout ? S_RESPOND : S_SETTLE;
         S_SETTLE:   state_n = (stable || timeout) ? S_RESPOND : S_SETTLE;
         S_RESPOND:  state_n = rsp_ready_i ? S_IDLE : S_RESPOND;
         default:    state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) state <= rst_i ? S_IDLE : state_n;

   // The op is dropped on the edge into CLEAR so a DECISION/BACKTRACK pulse lasts exactly the ISSUE cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         axi_reg0_o    <= '0;
         axi_reg1_o    <= '0;
         axi_reg2_o    <= '0;
         axi_reg3_o    <= '0;
         rsp_status_o  <= '0;
         rsp_impl_o    <= '0;
         rsp_timeout_o <= 1'b0;
         to_cnt        <= '0;
      end else begin
         if (accept) begin
            axi_reg0_o <= 32'({cmd_clause_id_i, cmd_op_i});
            axi_reg1_o <= 32'({cmd_var_ids_i[0*VEL +: VEL], cmd_pols_i[0]});
            axi_reg2_o <= 32'({cmd_var_ids_i[1*VEL +: VEL], cmd_pols_i[1]});
            axi_reg3_o <= 32'({cmd_var_ids_i[2*VEL +: VEL], cmd_pols_i[2]});
         end
         if (state_n == S_CLEAR || timeout) axi_reg0_o[REG0_OP_LSB +: 2] <= NO_OP;
         to_cnt <= state == S_ISSUE ? '0 : (timing && to_cnt != TO_LAST) ? to_cnt + 1'b1 : to_cnt;
         if (stable || timeout) begin
            rsp_status_o  <= axi_reg4_i;
            rsp_impl_o    <= axi_reg5_i;
            rsp_timeout_o <= !stable;
         end
      end
   end
endmodule
